// File: rtl/multi_cycle_ctrl_pkg.sv
// Shared encodings for the multi-cycle controller: FSM states, opcode/funct
// constants, ALU operation codes and datapath select codes.
package multi_cycle_ctrl_pkg;

    localparam logic [2:0] S_IF  = 3'd0;
    localparam logic [2:0] S_ID  = 3'd1;
    localparam logic [2:0] S_EX  = 3'd2;
    localparam logic [2:0] S_MEM = 3'd3;
    localparam logic [2:0] S_WB  = 3'd4;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_ADDI  = 6'b001000;
    localparam logic [5:0] OP_ANDI  = 6'b001100;
    localparam logic [5:0] OP_XORI  = 6'b001110;
    localparam logic [5:0] OP_SLTIU = 6'b001011;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_BNE   = 6'b000101;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_JAL   = 6'b000011;

    localparam logic [5:0] FN_ADD  = 6'b100000;
    localparam logic [5:0] FN_SUB  = 6'b100010;
    localparam logic [5:0] FN_AND  = 6'b100100;
    localparam logic [5:0] FN_OR   = 6'b100101;
    localparam logic [5:0] FN_XOR  = 6'b100110;
    localparam logic [5:0] FN_NOR  = 6'b100111;
    localparam logic [5:0] FN_SLTU = 6'b101011;
    localparam logic [5:0] FN_SLLV = 6'b000100;
    localparam logic [5:0] FN_JR   = 6'b001000;

    localparam logic [2:0] ALU_AND  = 3'b000;
    localparam logic [2:0] ALU_OR   = 3'b001;
    localparam logic [2:0] ALU_XOR  = 3'b010;
    localparam logic [2:0] ALU_NOR  = 3'b011;
    localparam logic [2:0] ALU_ADD  = 3'b100;
    localparam logic [2:0] ALU_SUB  = 3'b101;
    localparam logic [2:0] ALU_SLTU = 3'b110;
    localparam logic [2:0] ALU_SLLV = 3'b111;

    localparam logic [1:0] PC_SEQ = 2'b00;
    localparam logic [1:0] PC_JR  = 2'b01;
    localparam logic [1:0] PC_BR  = 2'b10;
    localparam logic [1:0] PC_JMP = 2'b11;

    localparam logic [1:0] WR_RD = 2'b00;
    localparam logic [1:0] WR_RT = 2'b01;
    localparam logic [1:0] WR_RA = 2'b10;

    localparam logic [1:0] WD_ALU = 2'b00;
    localparam logic [1:0] WD_MEM = 2'b01;
    localparam logic [1:0] WD_PC  = 2'b10;

    typedef enum logic [3:0] {
        CLS_R, CLS_JR, CLS_IMM, CLS_LW, CLS_SW,
        CLS_BEQ, CLS_BNE, CLS_J, CLS_JAL, CLS_ILL
    } cls_e;

endpackage

// File: rtl/multi_cycle_ctrl_if.sv
// Controller <-> datapath bundle. master is the controller side, slave the
// datapath/instruction-memory side.
interface multi_cycle_ctrl_if #(
    parameter int ALU_OP_W = 3,
    parameter int ADDR_W   = 26
);
    logic [31:0]         inst;
    logic                ZF;
    logic                IR_Write;
    logic                PC_Write;
    logic [ALU_OP_W-1:0] ALU_OP;
    logic [4:0]          rs;
    logic [4:0]          rt;
    logic [4:0]          rd;
    logic [15:0]         imm;
    logic [ADDR_W-1:0]   address;
    logic                Write_Reg;
    logic                Mem_Write;
    logic                imm_s;
    logic                rt_imm_s;
    logic [1:0]          w_r_s;
    logic [1:0]          wr_data_s;
    logic [1:0]          PC_s;
    logic [2:0]          state;
    logic                illegal;

    modport master (
        input  inst, ZF,
        output IR_Write, PC_Write, ALU_OP, rs, rt, rd, imm, address,
               Write_Reg, Mem_Write, imm_s, rt_imm_s, w_r_s, wr_data_s,
               PC_s, state, illegal
    );

    modport slave (
        output inst, ZF,
        input  IR_Write, PC_Write, ALU_OP, rs, rt, rd, imm, address,
               Write_Reg, Mem_Write, imm_s, rt_imm_s, w_r_s, wr_data_s,
               PC_s, state, illegal
    );
endinterface

// File: rtl/multi_cycle_ctrl_inst_decode.sv
// Purely combinational instruction classifier; produces the instruction class
// and the per-instruction datapath selects that the controller latches in ID.
module inst_decode
    import multi_cycle_ctrl_pkg::*;
(
    input  logic [31:0] inst,
    output cls_e        cls,
    output logic [2:0]  alu_op,
    output logic        imm_s,
    output logic        rt_imm_s,
    output logic [1:0]  w_r_s,
    output logic [1:0]  wr_data_s
);
    always_comb begin
        cls       = CLS_ILL;
        alu_op    = ALU_AND;
        imm_s     = 1'b0;
        rt_imm_s  = 1'b0;
        w_r_s     = WR_RD;
        wr_data_s = WD_ALU;
        case (inst[31:26])
            OP_RTYPE: begin
                cls = CLS_R;
                case (inst[5:0])
                    FN_ADD:  alu_op = ALU_ADD;
                    FN_SUB:  alu_op = ALU_SUB;
                    FN_AND:  alu_op = ALU_AND;
                    FN_OR:   alu_op = ALU_OR;
                    FN_XOR:  alu_op = ALU_XOR;
                    FN_NOR:  alu_op = ALU_NOR;
                    FN_SLTU: alu_op = ALU_SLTU;
                    FN_SLLV: alu_op = ALU_SLLV;
                    FN_JR:   cls    = CLS_JR;
                    default: cls    = CLS_ILL;
                endcase
            end
            OP_ADDI:  begin cls = CLS_IMM; alu_op = ALU_ADD;  imm_s = 1'b1; rt_imm_s = 1'b1; w_r_s = WR_RT; end
            OP_ANDI:  begin cls = CLS_IMM; alu_op = ALU_AND;  rt_imm_s = 1'b1; w_r_s = WR_RT; end
            OP_XORI:  begin cls = CLS_IMM; alu_op = ALU_XOR;  rt_imm_s = 1'b1; w_r_s = WR_RT; end
            OP_SLTIU: begin cls = CLS_IMM; alu_op = ALU_SLTU; rt_imm_s = 1'b1; w_r_s = WR_RT; end
            // Loads and stores use the ALU for base + sign-extended offset.
            OP_LW: begin
                cls = CLS_LW; alu_op = ALU_ADD; imm_s = 1'b1; rt_imm_s = 1'b1;
                w_r_s = WR_RT; wr_data_s = WD_MEM;
            end
            OP_SW:  begin cls = CLS_SW;  alu_op = ALU_ADD; imm_s = 1'b1; rt_imm_s = 1'b1; end
            OP_BEQ: begin cls = CLS_BEQ; alu_op = ALU_SUB; end
            OP_BNE: begin cls = CLS_BNE; alu_op = ALU_SUB; end
            OP_J:   cls = CLS_J;
            OP_JAL: begin cls = CLS_JAL; w_r_s = WR_RA; wr_data_s = WD_PC; end
            default: cls = CLS_ILL;
        endcase
    end
endmodule

// File: rtl/multi_cycle_ctrl.sv
// Multi-cycle MIPS-subset control FSM: IF/ID/EX/MEM/WB sequencing with a
// wait counter stretching IF and MEM by MEM_LAT cycles.
//   state | meaning
//   IF    | fetch; final cycle loads IR and PC+4
//   ID    | latch fields and selects; j jumps, undefined opcodes flag illegal
//   EX    | ALU op; jr and taken branches load PC
//   MEM   | data access; sw writes on the final cycle
//   WB    | register write-back; jal also loads PC
module multi_cycle_ctrl
    import multi_cycle_ctrl_pkg::*;
#(
    parameter int ALU_OP_W = 3,
    parameter int ADDR_W   = 26,
    parameter int MEM_LAT  = 0
) (
    input  logic              clk,
    input  logic              rst_n,
    multi_cycle_ctrl_if.master bus
);
    localparam logic [3:0] LAT = 4'(MEM_LAT);

    logic [2:0]          state_q, state_d;
    logic [3:0]          wait_cnt;
    logic                last_wait;
    cls_e                cls_q, cls_dec;
    logic [2:0]          alu_dec;
    logic                imm_s_dec, rt_imm_s_dec;
    logic [1:0]          w_r_s_dec, wr_data_s_dec;
    logic [ALU_OP_W-1:0] alu_op_q;
    logic [4:0]          rs_q, rt_q, rd_q;
    logic [15:0]         imm_q;
    logic [ADDR_W-1:0]   addr_q;
    logic                imm_s_q, rt_imm_s_q;
    logic [1:0]          w_r_s_q, wr_data_s_q, pc_s;

    inst_decode u_dec (
        .inst      (bus.inst),
        .cls       (cls_dec),
        .alu_op    (alu_dec),
        .imm_s     (imm_s_dec),
        .rt_imm_s  (rt_imm_s_dec),
        .w_r_s     (w_r_s_dec),
        .wr_data_s (wr_data_s_dec)
    );

    assign last_wait = (wait_cnt == LAT);

    always_comb begin
        state_d = S_IF;
        case (state_q)
            S_IF: state_d = last_wait ? S_ID : S_IF;
            S_ID: begin
                case (cls_dec)
                    CLS_R, CLS_JR, CLS_IMM, CLS_LW, CLS_SW, CLS_BEQ, CLS_BNE: state_d = S_EX;
                    CLS_JAL: state_d = S_WB;
                    default: state_d = S_IF;
                endcase
            end
            S_EX: begin
                case (cls_q)
                    CLS_R, CLS_IMM: state_d = S_WB;
                    CLS_LW, CLS_SW: state_d = S_MEM;
                    default:        state_d = S_IF;
                endcase
            end
            S_MEM: begin
                if (!last_wait)           state_d = S_MEM;
                else if (cls_q == CLS_LW) state_d = S_WB;
                else                      state_d = S_IF;
            end
            default: state_d = S_IF;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IF;
            wait_cnt <= 4'd0;
        end else begin
            state_q <= state_d;
            if ((state_q == S_IF || state_q == S_MEM) && !last_wait)
                wait_cnt <= wait_cnt + 4'd1;
            else
                wait_cnt <= 4'd0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cls_q       <= CLS_R;
            alu_op_q    <= '0;
            rs_q        <= '0;
            rt_q        <= '0;
            rd_q        <= '0;
            imm_q       <= '0;
            addr_q      <= '0;
            imm_s_q     <= 1'b0;
            rt_imm_s_q  <= 1'b0;
            w_r_s_q     <= '0;
            wr_data_s_q <= '0;
        end else if (state_q == S_ID) begin
            cls_q       <= cls_dec;
            alu_op_q    <= ALU_OP_W'(alu_dec);
            rs_q        <= bus.inst[25:21];
            rt_q        <= bus.inst[20:16];
            rd_q        <= bus.inst[15:11];
            imm_q       <= bus.inst[15:0];
            addr_q      <= bus.inst[ADDR_W-1:0];
            imm_s_q     <= imm_s_dec;
            rt_imm_s_q  <= rt_imm_s_dec;
            w_r_s_q     <= w_r_s_dec;
            wr_data_s_q <= wr_data_s_dec;
        end
    end

    always_comb begin
        pc_s = PC_SEQ;
        case (state_q)
            S_ID: if (cls_dec == CLS_J) pc_s = PC_JMP;
            S_EX: begin
                if (cls_q == CLS_JR)                            pc_s = PC_JR;
                else if (cls_q == CLS_BEQ || cls_q == CLS_BNE)  pc_s = PC_BR;
            end
            S_WB: if (cls_q == CLS_JAL) pc_s = PC_JMP;
            default: pc_s = PC_SEQ;
        endcase
    end

    // Strobes are gated by rst_n so nothing fires while reset is held.
    assign bus.IR_Write  = rst_n && state_q == S_IF && last_wait;
    assign bus.PC_Write  = rst_n && ((state_q == S_IF && last_wait)
                         || (state_q == S_ID && cls_dec == CLS_J)
                         || (state_q == S_EX && cls_q == CLS_JR)
                         || (state_q == S_EX && cls_q == CLS_BEQ && bus.ZF)
                         || (state_q == S_EX && cls_q == CLS_BNE && !bus.ZF)
                         || (state_q == S_WB && cls_q == CLS_JAL));
    assign bus.Write_Reg = rst_n && state_q == S_WB
                         && (cls_q == CLS_R || cls_q == CLS_IMM || cls_q == CLS_LW || cls_q == CLS_JAL);
    assign bus.Mem_Write = rst_n && state_q == S_MEM && last_wait && cls_q == CLS_SW;
    assign bus.illegal   = rst_n && state_q == S_ID && cls_dec == CLS_ILL;

    assign bus.state     = state_q;
    assign bus.PC_s      = pc_s;
    assign bus.ALU_OP    = alu_op_q;
    assign bus.rs        = rs_q;
    assign bus.rt        = rt_q;
    assign bus.rd        = rd_q;
    assign bus.imm       = imm_q;
    assign bus.address   = addr_q;
    assign bus.imm_s     = imm_s_q;
    assign bus.rt_imm_s  = rt_imm_s_q;
    assign bus.w_r_s     = w_r_s_q;
    assign bus.wr_data_s = wr_data_s_q;
endmodule

// File: tb/tb_multi_cycle_ctrl.sv
// Scoreboard bench: a behavioural trace model pushes per-cycle expectations,
// drained cycle by cycle against a MEM_LAT=0 and a MEM_LAT=2 controller.
module tb_multi_cycle_ctrl;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    multi_cycle_ctrl_if #(.ALU_OP_W(3), .ADDR_W(26)) b0 ();
    multi_cycle_ctrl_if #(.ALU_OP_W(3), .ADDR_W(26)) b2 ();

    multi_cycle_ctrl #(.ALU_OP_W(3), .ADDR_W(26), .MEM_LAT(0)) dut0 (.clk(clk), .rst_n(rst_n), .bus(b0));
    multi_cycle_ctrl #(.ALU_OP_W(3), .ADDR_W(26), .MEM_LAT(2)) dut2 (.clk(clk), .rst_n(rst_n), .bus(b2));

    typedef struct {
        logic [31:0] inst;
        logic        zf;
        logic [2:0]  state;
        logic        ir, pcw, wr, mw, ill;
        logic [1:0]  pc_s;
        logic        chk_f, chk_alu;
        logic [4:0]  rt, rd;
        logic [25:0] addr;
        logic [2:0]  alu;
        logic [1:0]  wrs, wds;
    } exp_t;

    exp_t sb[$];
    int   tests_run = 0;
    int   fails = 0;
    bit   use2 = 1'b0;
    bit   chk_mw = 1'b0;
    bit   mw_seen = 1'b0;

    logic [2:0]  o_state, o_alu;
    logic        o_ir, o_pcw, o_wr, o_mw, o_ill;
    logic [1:0]  o_pc_s, o_wrs, o_wds;
    logic [4:0]  o_rt, o_rd;
    logic [25:0] o_addr;

    always_comb begin
        o_state = use2 ? b2.state     : b0.state;
        o_ir    = use2 ? b2.IR_Write  : b0.IR_Write;
        o_pcw   = use2 ? b2.PC_Write  : b0.PC_Write;
        o_wr    = use2 ? b2.Write_Reg : b0.Write_Reg;
        o_mw    = use2 ? b2.Mem_Write : b0.Mem_Write;
        o_ill   = use2 ? b2.illegal   : b0.illegal;
        o_pc_s  = use2 ? b2.PC_s      : b0.PC_s;
        o_alu   = use2 ? b2.ALU_OP    : b0.ALU_OP;
        o_rt    = use2 ? b2.rt        : b0.rt;
        o_rd    = use2 ? b2.rd        : b0.rd;
        o_addr  = use2 ? b2.address   : b0.address;
        o_wrs   = use2 ? b2.w_r_s     : b0.w_r_s;
        o_wds   = use2 ? b2.wr_data_s : b0.wr_data_s;
    end

    always @(negedge clk) if (chk_mw && b2.Mem_Write) mw_seen = 1'b1;

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic drive(input logic [31:0] ins, input logic zf);
        b0.inst = ins; b2.inst = ins;
        b0.ZF = zf;    b2.ZF = zf;
    endtask

    // Expected per-cycle trace of one instruction, from the ISA description.
    task automatic push_inst(input logic [31:0] ins, input logic zf, input int lat);
        int cls; logic [2:0] alu; logic [1:0] wrs, wds; exp_t r;
        cls = 9; alu = 3'b000; wrs = 2'b00; wds = 2'b00;
        case (ins[31:26])
            6'h00: case (ins[5:0])
                6'h20: begin cls = 0; alu = 3'b100; end
                6'h22: begin cls = 0; alu = 3'b101; end
                6'h24: begin cls = 0; alu = 3'b000; end
                6'h25: begin cls = 0; alu = 3'b001; end
                6'h26: begin cls = 0; alu = 3'b010; end
                6'h27: begin cls = 0; alu = 3'b011; end
                6'h2B: begin cls = 0; alu = 3'b110; end
                6'h04: begin cls = 0; alu = 3'b111; end
                6'h08: cls = 1;
                default: cls = 9;
            endcase
            6'h08: begin cls = 2; alu = 3'b100; end
            6'h0C: begin cls = 2; alu = 3'b000; end
            6'h0E: begin cls = 2; alu = 3'b010; end
            6'h0B: begin cls = 2; alu = 3'b110; end
            6'h23: cls = 3;
            6'h2B: cls = 4;
            6'h04: begin cls = 5; alu = 3'b101; end
            6'h05: begin cls = 6; alu = 3'b101; end
            6'h02: cls = 7;
            6'h03: cls = 8;
            default: cls = 9;
        endcase
        if (cls == 2) wrs = 2'b01;
        if (cls == 3) begin wrs = 2'b01; wds = 2'b01; end
        if (cls == 8) begin wrs = 2'b10; wds = 2'b10; end

        r = '{default: 0};
        r.inst = ins; r.zf = zf;
        for (int i = 0; i <= lat; i++) begin
            r.state = 3'd0; r.ir = (i == lat); r.pcw = (i == lat); r.pc_s = 2'b00;
            sb.push_back(r);
        end
        r.ir = 1'b0; r.state = 3'd1;
        r.pcw = (cls == 7); r.pc_s = (cls == 7) ? 2'b11 : 2'b00;
        r.ill = (cls == 9);
        sb.push_back(r);
        if (cls == 7 || cls == 9) return;

        r.ill = 1'b0; r.pcw = 1'b0; r.pc_s = 2'b00;
        r.chk_f = 1'b1; r.rt = ins[20:16]; r.rd = ins[15:11]; r.addr = ins[25:0];
        r.chk_alu = (cls == 0 || cls == 2 || cls == 5 || cls == 6); r.alu = alu;
        r.wrs = wrs; r.wds = wds;
        if (cls != 8) begin
            r.state = 3'd2;
            if (cls == 1) begin r.pcw = 1'b1; r.pc_s = 2'b01; end
            if (cls == 5) begin r.pcw = zf;   r.pc_s = 2'b10; end
            if (cls == 6) begin r.pcw = !zf;  r.pc_s = 2'b10; end
            sb.push_back(r);
            r.pcw = 1'b0;
        end
        if (cls == 3 || cls == 4) begin
            for (int i = 0; i <= lat; i++) begin
                r.state = 3'd3; r.mw = (cls == 4 && i == lat);
                sb.push_back(r);
            end
            r.mw = 1'b0;
        end
        if (cls == 0 || cls == 2 || cls == 3 || cls == 8) begin
            r.state = 3'd4; r.wr = 1'b1;
            if (cls == 8) begin r.pcw = 1'b1; r.pc_s = 2'b11; end
            sb.push_back(r);
        end
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        @(negedge clk); @(negedge clk);
        rst_n = 1'b1;
    endtask

    // Scoreboard consumer: one popped record per cycle, then a final IF check.
    task automatic drain(input string tag);
        exp_t e; int n;
        n = 0;
        while (sb.size() > 0) begin
            e = sb.pop_front();
            drive(e.inst, e.zf);
            #1;
            tests_run++;
            if (o_state !== e.state || o_ir !== e.ir || o_pcw !== e.pcw || o_wr !== e.wr
                || o_mw !== e.mw || o_ill !== e.ill) begin
                fails++;
                $display("FAIL %s cyc%0d state/strobes: got st=%0d ir=%b pcw=%b wr=%b mw=%b ill=%b, want st=%0d ir=%b pcw=%b wr=%b mw=%b ill=%b",
                         tag, n, o_state, o_ir, o_pcw, o_wr, o_mw, o_ill,
                         e.state, e.ir, e.pcw, e.wr, e.mw, e.ill);
            end
            if (e.pcw) begin
                tests_run++;
                if (o_pc_s !== e.pc_s) begin
                    fails++;
                    $display("FAIL %s cyc%0d PC_s: got %b want %b", tag, n, o_pc_s, e.pc_s);
                end
            end
            if (e.chk_f) begin
                tests_run++;
                if (o_rt !== e.rt || o_rd !== e.rd || o_addr !== e.addr) begin
                    fails++;
                    $display("FAIL %s cyc%0d fields: got rt=%0d rd=%0d addr=%h want rt=%0d rd=%0d addr=%h",
                             tag, n, o_rt, o_rd, o_addr, e.rt, e.rd, e.addr);
                end
            end
            if (e.chk_alu) begin
                tests_run++;
                if (o_alu !== e.alu) begin
                    fails++;
                    $display("FAIL %s cyc%0d ALU_OP: got %b want %b", tag, n, o_alu, e.alu);
                end
            end
            if (e.wr) begin
                tests_run++;
                if (o_wrs !== e.wrs || o_wds !== e.wds) begin
                    fails++;
                    $display("FAIL %s cyc%0d selects: got w_r_s=%b wr_data_s=%b want %b %b",
                             tag, n, o_wrs, o_wds, e.wrs, e.wds);
                end
            end
            n++;
            @(negedge clk);
        end
        #1;
        tests_run++;
        if (o_state !== 3'd0) begin
            fails++;
            $display("FAIL %s end state: got %0d want 0", tag, o_state);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(32'h0022_1820, 1'b1);
        repeat (2) @(negedge clk);
        tests_run++;
        if (b0.state !== 3'd0 || b0.IR_Write !== 1'b0 || b0.PC_Write !== 1'b0 || b0.Write_Reg !== 1'b0
            || b0.Mem_Write !== 1'b0 || b0.illegal !== 1'b0 || b0.PC_s !== 2'b00) begin
            fails++;
            $display("FAIL reset0 ctrl: st=%0d ir=%b pcw=%b wr=%b mw=%b ill=%b pcs=%b, want all 0",
                     b0.state, b0.IR_Write, b0.PC_Write, b0.Write_Reg, b0.Mem_Write, b0.illegal, b0.PC_s);
        end
        tests_run++;
        if (b0.rs !== 5'd0 || b0.rt !== 5'd0 || b0.rd !== 5'd0 || b0.imm !== 16'd0 || b0.address !== 26'd0
            || b0.ALU_OP !== 3'd0 || b0.imm_s !== 1'b0 || b0.rt_imm_s !== 1'b0 || b0.w_r_s !== 2'b00
            || b0.wr_data_s !== 2'b00) begin
            fails++;
            $display("FAIL reset0 regs: rs=%0d rt=%0d rd=%0d imm=%h addr=%h alu=%b, want all 0",
                     b0.rs, b0.rt, b0.rd, b0.imm, b0.address, b0.ALU_OP);
        end
        tests_run++;
        if (b2.state !== 3'd0 || b2.IR_Write !== 1'b0 || b2.PC_Write !== 1'b0 || b2.Write_Reg !== 1'b0
            || b2.Mem_Write !== 1'b0 || b2.illegal !== 1'b0) begin
            fails++;
            $display("FAIL reset2 ctrl: st=%0d ir=%b pcw=%b, want all 0", b2.state, b2.IR_Write, b2.PC_Write);
        end
    endtask

    task automatic test_r_type();
        use2 = 1'b0;
        do_reset();
        push_inst(32'h0022_1820, 1'b0, 0);   // add $3,$1,$2
        push_inst(32'h0062_2022, 1'b0, 0);   // sub $4,$3,$2
        push_inst(32'h0043_2804, 1'b0, 0);   // sllv
        push_inst(32'h0022_302B, 1'b0, 0);   // sltu
        push_inst(32'h0022_3827, 1'b0, 0);   // nor
        drain("r_type");
    endtask

    task automatic test_imm_sw();
        use2 = 1'b0;
        do_reset();
        push_inst(32'h2022_FFFF, 1'b0, 0);   // addi
        push_inst(32'h3022_00F0, 1'b0, 0);   // andi
        push_inst(32'h3822_0F0F, 1'b0, 0);   // xori
        push_inst(32'h2C22_0010, 1'b0, 0);   // sltiu
        push_inst(32'hAC22_0004, 1'b0, 0);   // sw
        push_inst(32'h8C23_0008, 1'b0, 0);   // lw
        drain("imm_sw");
    endtask

    task automatic test_branch();
        use2 = 1'b0;
        do_reset();
        push_inst(32'h1022_0003, 1'b1, 0);   // beq taken
        push_inst(32'h1022_0003, 1'b0, 0);   // beq not taken
        push_inst(32'h1422_0003, 1'b0, 0);   // bne taken
        push_inst(32'h1422_0003, 1'b1, 0);   // bne not taken
        drain("branch");
    endtask

    task automatic test_jumps();
        use2 = 1'b0;
        do_reset();
        push_inst(32'h0C00_0010, 1'b0, 0);   // jal
        push_inst(32'h0800_0040, 1'b0, 0);   // j
        push_inst(32'h03E0_0008, 1'b0, 0);   // jr $31
        drain("jumps");
    endtask

    task automatic test_illegal();
        use2 = 1'b0;
        do_reset();
        push_inst(32'hFC00_0000, 1'b0, 0);
        push_inst(32'h0022_1801, 1'b0, 0);   // undefined funct
        push_inst(32'h0022_1820, 1'b0, 0);
        drain("illegal");
    endtask

    task automatic test_lw_lat2();
        use2 = 1'b1;
        do_reset();
        push_inst(32'h8C22_0004, 1'b0, 2);
        tests_run++;
        if (sb.size() != 9) begin
            fails++;
            $display("FAIL lw_lat2 model length: got %0d want 9", sb.size());
        end
        drain("lw_lat2");
    endtask

    task automatic test_back_to_back();
        use2 = 1'b1;
        do_reset();
        push_inst(32'hAC22_0004, 1'b0, 2);
        push_inst(32'h8C25_0000, 1'b0, 2);
        push_inst(32'h0C00_0123, 1'b0, 2);
        push_inst(32'h1022_0001, 1'b1, 2);
        drain("back_to_back");
    endtask

    task automatic test_sw_reset();
        bit found;
        use2 = 1'b1;
        do_reset();
        drive(32'hAC22_0004, 1'b0);
        mw_seen = 1'b0;
        chk_mw = 1'b1;
        found = 1'b0;
        for (int i = 0; i < 20 && !found; i++) begin
            #1;
            if (b2.state == 3'd3) found = 1'b1;
            else @(negedge clk);
        end
        tests_run++;
        if (!found) begin
            fails++;
            $display("FAIL sw_reset reach MEM: got state %0d want 3", b2.state);
        end
        rst_n = 1'b0;
        #1;
        tests_run++;
        if (b2.state !== 3'd0 || b2.Mem_Write !== 1'b0) begin
            fails++;
            $display("FAIL sw_reset during reset: got st=%0d mw=%b want 0 0", b2.state, b2.Mem_Write);
        end
        repeat (3) @(negedge clk);
        chk_mw = 1'b0;
        tests_run++;
        if (mw_seen !== 1'b0) begin
            fails++;
            $display("FAIL sw_reset Mem_Write seen: got %b want 0", mw_seen);
        end
        rst_n = 1'b1;
        push_inst(32'h0022_1820, 1'b0, 2);
        drain("after_reset");
    endtask

    initial begin
        drive(32'h0, 1'b0);
        test_reset();
        test_r_type();
        test_imm_sw();
        test_branch();
        test_jumps();
        test_illegal();
        test_lw_lat2();
        test_back_to_back();
        test_sw_reset();
        $display("[TB] %0d tests run, %0d failed", tests_run, fails);
        $finish;
    end
endmodule

// File: doc/multi_cycle_ctrl.md
MULTI_CYCLE_CTRL -- requirements
Module: multi_cycle_ctrl

Interface
REQ-001 Parameter ALU_OP_W, default 3: width of ALU_OP; values above 3 zero-extend the 3-bit codes.
REQ-002 Parameter ADDR_W, default 26: width of address; the low ADDR_W bits of inst[25:0] are used.
REQ-003 Parameter MEM_LAT, default 0, range 0..15: extra wait cycles spent in IF and in MEM.
REQ-004 clk  in  1  single clock; all state changes on its rising edge.
REQ-005 rst_n  in  1  asynchronous, active-low reset.
REQ-006 inst  in  32  instruction word from instruction memory; valid at the end of IF.
REQ-007 ZF  in  1  ALU zero flag; valid during EX.
REQ-008 IR_Write, PC_Write  out  1 each  instruction-register load strobe and PC load strobe.
REQ-009 ALU_OP  out  ALU_OP_W  add 100, sub 101, and 000, or 001, xor 010, nor 011, sltu 110, sllv 111.
REQ-010 rs, rt, rd  out  5 each  register fields latched in ID.
REQ-011 imm  out  16  latched immediate field; address  out  ADDR_W  latched jump target field.
REQ-012 Write_Reg, Mem_Write  out  1 each  register-file and data-memory write strobes.
REQ-013 imm_s, rt_imm_s  out  1 each  sign-extend select and ALU operand-B immediate select.
REQ-014 w_r_s, wr_data_s, PC_s  out  2 each  write-register select, write-data select, PC source select.
REQ-015 state  out  3  current FSM state; illegal  out  1  one-cycle undefined-opcode pulse.

Function
REQ-016 States: IF=0, ID=1, EX=2, MEM=3, WB=4; encodings 5..7 shall return to IF on the next edge.
REQ-017 IF: hold for MEM_LAT cycles using a wait counter; on the final IF cycle assert IR_Write=1, PC_Write=1, PC_s=00; then go to ID.
REQ-018 ID: latch rs, rt, rd, imm and address from inst; register ALU_OP, imm_s, rt_imm_s, w_r_s, wr_data_s and the instruction class; all strobes are 0.
REQ-019 R-type functs 100000/100010/100100/100101/100110/100111/101011/000100: map to add/sub/and/or/xor/nor/sltu/sllv; sequence ID->EX->WB; in WB assert Write_Reg=1 with w_r_s=00 and wr_data_s=00.
REQ-020 jr (funct 001000): ID->EX; in EX assert PC_Write=1 with PC_s=01; Write_Reg stays 0.
REQ-021 addi/andi/xori/sltiu (opcodes 001000/001100/001110/001011): imm_s = 1/0/0/0; ALU_OP = add/and/xor/sltu; rt_imm_s=1; in WB assert Write_Reg=1 with w_r_s=01.
REQ-022 lw (100011): sequence EX->MEM->WB; MEM holds MEM_LAT+1 cycles; in WB assert Write_Reg=1, w_r_s=01, wr_data_s=01.
REQ-023 sw (101011): sequence EX->MEM; assert Mem_Write=1 only on the final MEM cycle; then go to IF.
REQ-024 beq/bne (000100/000101): ALU_OP=sub and rt_imm_s=0 in EX; PC_Write=1 with PC_s=10 only if ZF=1 (beq) or ZF=0 (bne); then go to IF.
REQ-025 j (000010): in ID assert PC_Write=1 with PC_s=11; then go to IF.
REQ-026 jal (000011): ID->WB; in WB assert Write_Reg=1, w_r_s=10, wr_data_s=10, PC_Write=1, PC_s=11.
REQ-027 An undefined opcode or funct in ID shall pulse illegal=1 for one cycle, assert no strobe, and go to IF.
REQ-028 Each strobe shall be active for exactly one cycle per instruction, except IR_Write, which is active only on the final IF cycle.
REQ-029 Cycle counts at MEM_LAT=0: R/I-arith 4, lw 5, sw 4, branch 3, jr 3, j 2, jal 3.

Reset
REQ-030 While rst_n=0: state=IF, wait counter=0, all strobes and illegal=0, and rs/rt/rd/imm/address/ALU_OP and all select outputs=0.
REQ-031 Reset asserted mid-instruction shall abort the instruction without producing any write strobe; the first edge after release shall begin IF.

Structure
REQ-032 A shared package shall hold the state encodings, the opcode and funct constants, the ALU_OP codes, and the PC_s, w_r_s and wr_data_s select codes.
REQ-033 Combinational field decode shall sit in one sub-module, inst_decode; the FSM, wait counter and field registers stay in multi_cycle_ctrl.

Verification
REQ-034 MEM_LAT=0, inst=0x00221820 (add $3,$1,$2) -> states IF,ID,EX,WB; ALU_OP=100; Write_Reg=1 only in WB with rd=3.
REQ-035 MEM_LAT=2, inst=0x8C220004 (lw) -> IF 3 cycles, MEM 3 cycles; Write_Reg=1 in WB with wr_data_s=01 and rt=2; 9 cycles total.
REQ-036 inst=0x10220003 (beq) with ZF=1, then ZF=0 -> PC_Write=1 with PC_s=10 in EX for the first case only; both return to IF after 3 cycles.
REQ-037 inst=0x0C000010 (jal) -> in WB: Write_Reg=1, w_r_s=10, PC_s=11, address=0x10.
REQ-038 inst=0xFC000000 -> illegal=1 for one cycle in ID, no strobes, next state IF; rst_n pulsed low during MEM of sw -> Mem_Write never 1 and state=IF.
